// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Types and default sizes shared by the board memory and the life update
// engine.
//   board_state_t : board memory controller state (IDLE / CLEAR)
//   bank_t        : index of a board bank (0 or 1)
//   LIFE_ADDR_SIZE / LIFE_LINE_WIDTH : default line address width and
//                                      cells per line
// -----------------------------------------------------------------------------
package life_pkg;

  localparam int LIFE_ADDR_SIZE  = 10;
  localparam int LIFE_LINE_WIDTH = 8;

  typedef enum logic {ST_IDLE, ST_CLEAR} board_state_t;

  typedef logic bank_t;

endpackage

// File: rtl/life_board_mem_if.sv
// -----------------------------------------------------------------------------
// life_board_mem_if
// Line read/write interface between the life update engine (master) and the
// double-buffered board memory (slave).
//   addr_r_in / data_r_out : engine read of the front bank, 1-cycle latency
//   addr_w_in / data_w_in / we_in : engine write into the back bank
//   swap_in   : one-cycle pulse, generation done, exchange banks
//   clear_in  : one-cycle pulse, zero both banks
//   busy_out  : high while clearing; engine must stall (no valid/ready here:
//               while busy_out=1 every write/swap/clear request is dropped,
//               and read data returns 0)
//   bank_out  : index of the current front bank
//   state_dbg : controller state, for observation only
//   disp_addr_in / disp_data_out : display read of the front bank, present
//               only when LIFE_BOARD_MEM_DISPLAY_PORT_EN is defined
// -----------------------------------------------------------------------------
interface life_board_mem_if
  import life_pkg::*;
#(
  parameter int ADDR_SIZE  = LIFE_ADDR_SIZE,
  parameter int LINE_WIDTH = LIFE_LINE_WIDTH
) ();

  logic [ADDR_SIZE-1:0]  addr_r_in;
  logic [LINE_WIDTH-1:0] data_r_out;
  logic [ADDR_SIZE-1:0]  addr_w_in;
  logic [LINE_WIDTH-1:0] data_w_in;
  logic                  we_in;
  logic                  swap_in;
  logic                  clear_in;
  logic                  busy_out;
  bank_t                 bank_out;
  board_state_t          state_dbg;
`ifdef LIFE_BOARD_MEM_DISPLAY_PORT_EN
  logic [ADDR_SIZE-1:0]  disp_addr_in;
  logic [LINE_WIDTH-1:0] disp_data_out;

  modport master (
    output addr_r_in, addr_w_in, data_w_in, we_in, swap_in, clear_in,
           disp_addr_in,
    input  data_r_out, busy_out, bank_out, state_dbg, disp_data_out
  );

  modport slave (
    input  addr_r_in, addr_w_in, data_w_in, we_in, swap_in, clear_in,
           disp_addr_in,
    output data_r_out, busy_out, bank_out, state_dbg, disp_data_out
  );
`else
  modport master (
    output addr_r_in, addr_w_in, data_w_in, we_in, swap_in, clear_in,
    input  data_r_out, busy_out, bank_out, state_dbg
  );

  modport slave (
    input  addr_r_in, addr_w_in, data_w_in, we_in, swap_in, clear_in,
    output data_r_out, busy_out, bank_out, state_dbg
  );
`endif

endinterface

// File: rtl/line_ram.sv
// -----------------------------------------------------------------------------
// line_ram
// One board bank: DEPTH lines of LINE_WIDTH bits, one synchronous write port
// and N_RD registered read ports (1-cycle latency). No reset on contents or
// read registers so it maps onto block RAM.
//   clk     : clock
//   i_we    : write enable
//   i_waddr / i_wdata : write address / data
//   i_raddr : N_RD read addresses, port g at bits [g*ADDR_SIZE +: ADDR_SIZE]
//   o_rdata : N_RD read data words, port g at bits [g*LINE_WIDTH +: LINE_WIDTH]
// -----------------------------------------------------------------------------
module line_ram #(
  parameter int ADDR_SIZE  = 10,
  parameter int LINE_WIDTH = 8,
  parameter int N_RD       = 1
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [ADDR_SIZE-1:0]       i_waddr,
  input  logic [LINE_WIDTH-1:0]      i_wdata,
  input  logic [N_RD*ADDR_SIZE-1:0]  i_raddr,
  output logic [N_RD*LINE_WIDTH-1:0] o_rdata
);

  logic [LINE_WIDTH-1:0] r_mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [LINE_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
      r_q <= r_mem[i_raddr[g*ADDR_SIZE +: ADDR_SIZE]];
    end

    assign o_rdata[g*LINE_WIDTH +: LINE_WIDTH] = r_q;
  end

endmodule

// File: rtl/life_board_mem.sv
// -----------------------------------------------------------------------------
// life_board_mem
// Double-buffered board memory for the life update engine. The engine reads
// generation N from the front bank (bank_out) and writes generation N+1 into
// the back bank (~bank_out); swap_in exchanges them. After reset, or on
// clear_in, both banks are zeroed one line per cycle (DEPTH cycles) while
// busy_out is high.
// Build option: define LIFE_BOARD_MEM_DISPLAY_PORT_EN to add a display read
// port (disp_addr_in / disp_data_out) on the front bank.
// Ports:
//   clk_in   : clock
//   rst_n_in : asynchronous active-low reset
//   bus      : life_board_mem_if.slave (engine and display signals)
// -----------------------------------------------------------------------------
module life_board_mem
  import life_pkg::*;
#(
  parameter int ADDR_SIZE  = LIFE_ADDR_SIZE,
  parameter int LINE_WIDTH = LIFE_LINE_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  life_board_mem_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_SIZE;
  localparam int CW    = ADDR_SIZE + 1;
`ifdef LIFE_BOARD_MEM_DISPLAY_PORT_EN
  localparam int N_RD  = 2;
`else
  localparam int N_RD  = 1;
`endif

  board_state_t          r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  bank_t                 r_bank, w_bank_nxt;
  logic                  r_busy;
  logic                  r_rd_ok;    // read captured at the last edge is valid
  bank_t                 r_rd_bank;  // front bank at the edge the read was taken
  logic [1:0]            w_we;       // bit b = write enable of bank b
  logic [ADDR_SIZE-1:0]  w_waddr;
  logic [LINE_WIDTH-1:0] w_wdata;
  logic [N_RD*ADDR_SIZE-1:0]  w_raddr;
  logic [N_RD*LINE_WIDTH-1:0] w_q0, w_q1;

  // Next-state, bank select and RAM write control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bank_nxt  = r_bank;
    w_we        = 2'b00;
    w_waddr     = bus.addr_w_in;
    w_wdata     = bus.data_w_in;
    case (r_state)
      ST_CLEAR: begin
        // Engine requests are all dropped here; both banks take a zero line.
        w_we      = 2'b11;
        w_waddr   = r_cnt[ADDR_SIZE-1:0];
        w_wdata   = '0;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(DEPTH - 1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // The write targets the pre-swap back bank even in a swap cycle.
        if (bus.we_in) begin
          w_we = r_bank ? 2'b01 : 2'b10;
        end
        if (bus.clear_in) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end else if (bus.swap_in) begin
          w_bank_nxt = ~r_bank;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state   <= ST_CLEAR;
      r_cnt     <= '0;
      r_bank    <= 1'b0;
      r_busy    <= 1'b1;
      r_rd_ok   <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bank    <= w_bank_nxt;
      r_busy    <= (w_state_nxt == ST_CLEAR);
      // Reads taken while clearing, or on the clear_in edge, return 0.
      r_rd_ok   <= (r_state == ST_IDLE) && !bus.clear_in;
      r_rd_bank <= r_bank;
    end
  end

  // Both banks read the same address; the registered bank index picks one.
`ifdef LIFE_BOARD_MEM_DISPLAY_PORT_EN
  assign w_raddr = {bus.disp_addr_in, bus.addr_r_in};
`else
  assign w_raddr = bus.addr_r_in;
`endif

  line_ram #(
    .ADDR_SIZE  (ADDR_SIZE),
    .LINE_WIDTH (LINE_WIDTH),
    .N_RD       (N_RD)
  ) u_bank0 (
    .clk     (clk_in),
    .i_we    (w_we[0]),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_q0)
  );

  line_ram #(
    .ADDR_SIZE  (ADDR_SIZE),
    .LINE_WIDTH (LINE_WIDTH),
    .N_RD       (N_RD)
  ) u_bank1 (
    .clk     (clk_in),
    .i_we    (w_we[1]),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_q1)
  );

  assign bus.data_r_out = !r_rd_ok ? '0 :
                          (r_rd_bank ? w_q1[LINE_WIDTH-1:0] : w_q0[LINE_WIDTH-1:0]);
`ifdef LIFE_BOARD_MEM_DISPLAY_PORT_EN
  assign bus.disp_data_out = !r_rd_ok ? '0 :
                             (r_rd_bank ? w_q1[2*LINE_WIDTH-1:LINE_WIDTH]
                                        : w_q0[2*LINE_WIDTH-1:LINE_WIDTH]);
`endif
  assign bus.busy_out  = r_busy;
  assign bus.bank_out  = r_bank;
  assign bus.state_dbg = r_state;

endmodule
